// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with signs applied in a final fixup cycle.
module mul_div_unit #(
    parameter int         WIDTH  = 32,
    parameter logic [4:0] OP_MUL = 5'b01010,
    parameter logic [4:0] OP_DIV = 5'b01011
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] z_high,
    output logic [WIDTH-1:0] z_low,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_a, mag_b, orig_a;
    logic               sign_a, sign_b, is_div, is_dz;

    logic               accept, b_zero;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_neg;
    logic [WIDTH-1:0]   quo, rem;

    // Handshake: a request is taken only when start is high in IDLE with a
    // legal op; busy covers ITER..FIXUP and done pulses for one cycle after.
    assign accept = (state == IDLE) && start && (op == OP_MUL || op == OP_DIV);
    assign b_zero = (b == '0);

    assign busy      = (state == ITER) || (state == FIXUP);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (op == OP_DIV && b_zero) ? FIXUP : ITER;
            ITER:    if (count == CW'(1)) state_nx = FIXUP;
            FIXUP:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    assign mul_addend = acc[0] ? mag_a : {WIDTH{1'b0}};
    assign mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    assign mul_next   = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits / quotient bits}, shifted left.
    assign div_shift = {acc, 1'b0};
    assign div_diff  = div_shift[2*WIDTH:WIDTH] - {1'b0, mag_b};
    assign div_next  = div_diff[WIDTH] ? div_shift[2*WIDTH-1:0]
                                       : {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};

    assign prod_neg = -acc;
    assign quo      = acc[WIDTH-1:0];
    assign rem      = acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            count       <= '0;
            acc         <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            orig_a      <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            is_div      <= 1'b0;
            is_dz       <= 1'b0;
            div_by_zero <= 1'b0;
            z_high      <= '0;
            z_low       <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    mag_a       <= a[WIDTH-1] ? -a : a;
                    mag_b       <= b[WIDTH-1] ? -b : b;
                    orig_a      <= a;
                    sign_a      <= a[WIDTH-1];
                    sign_b      <= b[WIDTH-1];
                    is_div      <= (op == OP_DIV);
                    is_dz       <= (op == OP_DIV) && b_zero;
                    count       <= CW'(WIDTH);
                    div_by_zero <= 1'b0;
                    if (op == OP_DIV) acc <= {{WIDTH{1'b0}}, (a[WIDTH-1] ? -a : a)};
                    else              acc <= {{WIDTH{1'b0}}, (b[WIDTH-1] ? -b : b)};
                end
                ITER: begin
                    count <= count - CW'(1);
                    acc   <= is_div ? div_next : mul_next;
                end
                FIXUP: begin
                    if (is_dz) begin
                        z_low       <= '1;
                        z_high      <= orig_a;
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        z_low  <= (sign_a ^ sign_b) ? -quo : quo;
                        z_high <= sign_a ? -rem : rem;
                    end else begin
                        {z_high, z_low} <= (sign_a ^ sign_b) ? prod_neg : acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed scoreboard bench for mul_div_unit: results and latencies queued at
// issue time, popped and compared by a monitor on every done pulse.
module tb_mul_div_unit;

    localparam logic [4:0] OP_MUL = 5'b01010;
    localparam logic [4:0] OP_DIV = 5'b01011;

    logic        Clock, clear, start;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [31:0] z_high, z_low;
    logic [1:0]  dbg_state;

    logic [64:0] exp_q[$];
    int          lat_q[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, acc_cyc = 0, done_cnt = 0;

    mul_div_unit dut (
        .Clock(Clock), .clear(clear), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .z_high(z_high), .z_low(z_low), .dbg_state(dbg_state)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // monitor / scoreboard
    always @(negedge Clock) begin
        if (clear && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with empty queue at cycle %0d", cyc);
            end else begin
                logic [64:0] e;
                int l;
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                check("result{dz,zh,zl}", {31'b0, div_by_zero, z_high, z_low}, {31'b0, e});
                check("latency", 96'(cyc - acc_cyc), 96'(l));
            end
        end
    end

    // driver: one accepted request, optional start pulses while busy
    task automatic run_op(input logic [4:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input logic [64:0] expv, input int lat, input bit disturb,
                          output int busy_cycles);
        int n;
        bit seen;
        exp_q.push_back(expv);
        lat_q.push_back(lat);
        busy_cycles = 0;
        seen = 0;
        @(negedge Clock);
        start = 1'b1; op = o; a = va; b = vb;
        @(posedge Clock);
        acc_cyc = cyc;
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
        n = done_cnt;
        for (int i = 0; i < 80; i++) begin
            @(negedge Clock);
            if (disturb && i >= 5 && i <= 7) begin
                start = 1'b1; op = OP_MUL; a = 32'd2; b = 32'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (busy) busy_cycles++;
            if (done_cnt != n) begin
                seen = 1;
                break;
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within 80 cycles, required one");
        end
    endtask

    initial begin
        int bc, dc;
        clear = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge Clock);
        #1;
        check("reset_outputs", {busy, done, div_by_zero, z_high, z_low}, '0);
        check("reset_state", 96'(dbg_state), 96'(0));
        @(negedge Clock);
        clear = 1'b1;

        run_op(OP_DIV, 32'd12, 32'd5, {1'b0, 32'd2, 32'd2}, 34, 0, bc);
        check("div_busy_cycles", 96'(bc), 96'(33));
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 0, bc);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h0, 32'h8000_0000}, 34, 0, bc);
        run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, {1'b0, 32'd2, 32'hFFFF_FFF2}, 34, 0, bc);
        run_op(OP_MUL, 32'hFFFF_FFFF, 32'd3, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 0, bc);
        run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, {1'b0, 32'd1, 32'd0}, 34, 0, bc);
        run_op(OP_MUL, 32'hFFFF_FFFB, 32'hFFFF_FFFA, {1'b0, 32'd0, 32'd30}, 34, 0, bc);
        check("mul_busy_cycles", 96'(bc), 96'(33));

        // divide by zero, flag held while idle, cleared by next accept
        run_op(OP_DIV, 32'd9, 32'd0, {1'b1, 32'd9, 32'hFFFF_FFFF}, 2, 0, bc);
        repeat (4) @(negedge Clock);
        #1;
        check("dz_held", {div_by_zero, z_high, z_low}, {1'b1, 32'd9, 32'hFFFF_FFFF});
        run_op(OP_DIV, 32'd12, 32'd5, {1'b0, 32'd2, 32'd2}, 34, 0, bc);

        // illegal op ignored
        @(negedge Clock);
        start = 1'b1; op = 5'b00011; a = 32'd7; b = 32'd1;
        @(negedge Clock);
        start = 1'b0;
        repeat (3) @(negedge Clock);
        #1;
        check("illegal_op_idle", {dbg_state, busy, done}, '0);
        check("illegal_op_z_hold", {z_high, z_low}, {32'd2, 32'd2});

        // reset mid-operation: no done, outputs cleared
        dc = done_cnt;
        @(negedge Clock);
        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
        @(negedge Clock);
        start = 1'b0;
        repeat (9) @(negedge Clock);
        #1;
        check("busy_before_abort", 96'(busy), 96'(1));
        clear = 1'b0;
        #1;
        check("abort_outputs", {busy, done, div_by_zero, z_high, z_low}, '0);
        repeat (2) @(negedge Clock);
        clear = 1'b1;
        repeat (40) @(negedge Clock);
        #1;
        check("abort_no_done", 96'(done_cnt), 96'(dc));
        run_op(OP_DIV, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14}, 34, 0, bc);

        // start re-asserted while busy is neither queued nor disruptive
        dc = done_cnt;
        run_op(OP_DIV, 32'd12, 32'd5, {1'b0, 32'd2, 32'd2}, 34, 1, bc);
        repeat (45) @(negedge Clock);
        #1;
        check("single_done_when_restarted", 96'(done_cnt - dc), 96'(1));
        check("z_after_restart", {z_high, z_low}, {32'd2, 32'd2});

        check("queue_drained", 96'(exp_q.size()), 96'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
